// File: rtl/qrotate_pkg.sv
// rtl/qrotate_pkg.sv - constants, CORDIC arctangent table and FSM state type for qrotate
package qrotate_pkg;

  localparam int QUANT_BITS = 10;
  localparam int PI_Q       = 3217;
  localparam int HALF_PI_Q  = 1608;
  localparam int TWO_PI_Q   = 6434;
  localparam int CORDIC_K   = 622;
  localparam int ITERS      = 10;
  localparam int MAX_INC    = PI_Q - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // atan(2^-i) in Q10 radians for the ten micro-rotations
  function automatic logic signed [31:0] atan_q(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_q = 32'sd804;
      4'd1:    atan_q = 32'sd475;
      4'd2:    atan_q = 32'sd251;
      4'd3:    atan_q = 32'sd127;
      4'd4:    atan_q = 32'sd64;
      4'd5:    atan_q = 32'sd32;
      4'd6:    atan_q = 32'sd16;
      4'd7:    atan_q = 32'sd8;
      4'd8:    atan_q = 32'sd4;
      4'd9:    atan_q = 32'sd2;
      default: atan_q = 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/qrotate_iter.sv
// rtl/qrotate_iter.sv - one CORDIC rotation-mode micro-rotation; QROTATE_ROUND_EN selects rounded shifts
module qrotate_iter
  import qrotate_pkg::*;
(
  input  logic signed [31:0] i_x,
  input  logic signed [31:0] i_y,
  input  logic signed [31:0] i_z,
  input  logic        [3:0]  i_idx,
  output logic signed [31:0] o_x,
  output logic signed [31:0] o_y,
  output logic signed [31:0] o_z
);

  logic signed [31:0] w_rnd;
  logic signed [31:0] w_xs;
  logic signed [31:0] w_ys;
  logic               w_neg;

`ifdef QROTATE_ROUND_EN
  // half-LSB bias so the shift rounds instead of truncating; no bias on the unshifted first step
  assign w_rnd = (i_idx == 4'd0) ? 32'sd0 : (32'sd1 <<< (i_idx - 4'd1));
`else
  assign w_rnd = 32'sd0;
`endif

  assign w_xs  = (i_x + w_rnd) >>> i_idx;
  assign w_ys  = (i_y + w_rnd) >>> i_idx;
  assign w_neg = i_z[31];

  // rotate toward z = 0: d = +1 for z >= 0, -1 for z < 0
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (w_neg) begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + atan_q(i_idx);
    end else begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - atan_q(i_idx);
    end
  end

endmodule

// File: rtl/qrotate.sv
// rtl/qrotate.sv - FM modulator: phase accumulator plus iterative CORDIC to I/Q (QROTATE_ROUND_EN in qrotate_iter)
module qrotate
  import qrotate_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               freq_valid,
  output logic               freq_ready,
  input  logic signed [31:0] freq_in,
  input  logic               phase_clear,
  output logic               iq_valid,
  input  logic               iq_ready,
  output logic signed [31:0] i_out,
  output logic signed [31:0] q_out
);

  state_t             r_state;
  state_t             w_next_state;
  logic signed [31:0] r_acc;
  logic signed [31:0] r_x;
  logic signed [31:0] r_y;
  logic signed [31:0] r_z;
  logic        [3:0]  r_iter;
  logic               r_neg;
  logic signed [31:0] r_i;
  logic signed [31:0] r_q;

  logic               w_accept;
  logic               w_last;
  logic signed [31:0] w_inc;
  logic signed [31:0] w_base;
  logic signed [31:0] w_sum;
  logic signed [31:0] w_ph;
  logic signed [31:0] w_z0;
  logic               w_neg0;
  logic signed [31:0] w_xn;
  logic signed [31:0] w_yn;
  logic signed [31:0] w_zn;

  assign freq_ready = (r_state == S_IDLE);
  assign iq_valid   = (r_state == S_DONE);
  assign i_out      = r_i;
  assign q_out      = r_q;
  assign w_accept   = freq_valid && (r_state == S_IDLE);
  assign w_last     = (r_iter == 4'(ITERS - 1));

  // clamp the increment, add it to the (possibly cleared) phase, wrap into [-pi, pi), fold to +/-pi/2
  always_comb begin
    w_inc  = freq_in;
    if (freq_in > MAX_INC) begin
      w_inc = MAX_INC;
    end else if (freq_in < -MAX_INC) begin
      w_inc = -MAX_INC;
    end
    w_base = phase_clear ? 32'sd0 : r_acc;
    w_sum  = w_base + w_inc;
    w_ph   = w_sum;
    if (w_sum >= PI_Q) begin
      w_ph = w_sum - TWO_PI_Q;
    end else if (w_sum < -PI_Q) begin
      w_ph = w_sum + TWO_PI_Q;
    end
    w_z0   = w_ph;
    w_neg0 = 1'b0;
    if (w_ph > HALF_PI_Q) begin
      w_z0   = w_ph - PI_Q;
      w_neg0 = 1'b1;
    end else if (w_ph < -HALF_PI_Q) begin
      w_z0   = w_ph + PI_Q;
      w_neg0 = 1'b1;
    end
  end

  qrotate_iter u_iter (
    .i_x   (r_x),
    .i_y   (r_y),
    .i_z   (r_z),
    .i_idx (r_iter),
    .o_x   (w_xn),
    .o_y   (w_yn),
    .o_z   (w_zn)
  );

  // next-state: accept starts rotation, tenth iteration ends it, downstream ready releases the result
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_ROTATE;
      S_ROTATE: if (w_last)   w_next_state = S_DONE;
      S_DONE:   if (iq_ready) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // accumulator, CORDIC working registers and held I/Q results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_iter <= '0;
      r_neg  <= 1'b0;
      r_i    <= '0;
      r_q    <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= w_ph;
      end else if (phase_clear) begin
        r_acc <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x    <= CORDIC_K;
            r_y    <= '0;
            r_z    <= w_z0;
            r_neg  <= w_neg0;
            r_iter <= '0;
          end
        end
        S_ROTATE: begin
          r_x    <= w_xn;
          r_y    <= w_yn;
          r_z    <= w_zn;
          r_iter <= r_iter + 4'd1;
          if (w_last) begin
            r_iter <= '0;
            r_i    <= r_neg ? -w_xn : w_xn;
            r_q    <= r_neg ? -w_yn : w_yn;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qrotate.sv
// tb/tb_qrotate.sv - self-checking bench for qrotate against a trigonometric phase model
module tb_qrotate;

  logic               clk;
  logic               reset;
  logic               freq_valid;
  logic               freq_ready;
  logic signed [31:0] freq_in;
  logic               phase_clear;
  logic               iq_valid;
  logic               iq_ready;
  logic signed [31:0] i_out;
  logic signed [31:0] q_out;

  int n_checks;
  int n_errors;
  int m_acc;

  localparam int TOL      = 3;
  localparam int TOL_RAND = 5;
  localparam int LATENCY  = 10;

  qrotate dut (
    .clk         (clk),
    .reset       (reset),
    .freq_valid  (freq_valid),
    .freq_ready  (freq_ready),
    .freq_in     (freq_in),
    .phase_clear (phase_clear),
    .iq_valid    (iq_valid),
    .iq_ready    (iq_ready),
    .i_out       (i_out),
    .q_out       (q_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phase after one accepted sample, straight from the clamp / wrap rules
  function automatic int model_next(input int acc, input int f, input bit clr);
    int inc;
    int ph;
    inc = (f > 3216) ? 3216 : ((f < -3216) ? -3216 : f);
    ph  = (clr ? 0 : acc) + inc;
    if (ph >= 3217) ph -= 6434;
    else if (ph < -3217) ph += 6434;
    return ph;
  endfunction

  function automatic int exp_cos(input int ph);
    return int'($cos(ph / 1024.0) * 1024.0);
  endfunction

  function automatic int exp_sin(input int ph);
    return int'($sin(ph / 1024.0) * 1024.0);
  endfunction

  function automatic int adiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    freq_valid  = 1'b0;
    freq_in     = '0;
    phase_clear = 1'b0;
    iq_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_acc = 0;
  endtask

  // present one sample, wait (bounded) for iq_valid; lat = -1 if it never comes
  task automatic start_sample(input int f, input bit clr, output int lat);
    int c;
    @(negedge clk);
    freq_in     = f;
    freq_valid  = 1'b1;
    phase_clear = clr;
    @(posedge clk);
    #1;
    freq_valid  = 1'b0;
    phase_clear = 1'b0;
    m_acc = model_next(m_acc, f, clr);
    lat = -1;
    c = 0;
    while (lat < 0 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (iq_valid) lat = c;
    end
  endtask

  task automatic release_sample();
    @(negedge clk);
    iq_ready = 1'b1;
    @(posedge clk);
    #1;
    iq_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (freq_ready !== 1'b1) begin n_errors++; $display("FAIL reset_freq_ready got %b want 1", freq_ready); end
    n_checks++;
    if (iq_valid !== 1'b0) begin n_errors++; $display("FAIL reset_iq_valid got %b want 0", iq_valid); end
    n_checks++;
    if (i_out !== 32'sd0) begin n_errors++; $display("FAIL reset_i_out got %0d want 0", i_out); end
    n_checks++;
    if (q_out !== 32'sd0) begin n_errors++; $display("FAIL reset_q_out got %0d want 0", q_out); end
  endtask

  task automatic test_zero();
    int lat;
    do_reset();
    start_sample(0, 1'b0, lat);
    n_checks++;
    if (lat !== LATENCY) begin n_errors++; $display("FAIL zero_latency got %0d want %0d", lat, LATENCY); end
    n_checks++;
    if (adiff(i_out, 1024) > TOL) begin n_errors++; $display("FAIL zero_i got %0d want 1024+/-%0d", i_out, TOL); end
    n_checks++;
    if (adiff(q_out, 0) > TOL) begin n_errors++; $display("FAIL zero_q got %0d want 0+/-%0d", q_out, TOL); end
    release_sample();
    n_checks++;
    if (freq_ready !== 1'b1 || iq_valid !== 1'b0) begin
      n_errors++; $display("FAIL zero_back_idle got ready=%b valid=%b want 1/0", freq_ready, iq_valid);
    end
  endtask

  task automatic test_quarter_steps();
    int lat;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      start_sample(804, 1'b0, lat);
      n_checks++;
      if (lat !== LATENCY) begin n_errors++; $display("FAIL pi4_latency[%0d] got %0d want %0d", k, lat, LATENCY); end
      n_checks++;
      if (adiff(i_out, exp_cos(m_acc)) > TOL) begin
        n_errors++; $display("FAIL pi4_i[%0d] got %0d want %0d", k, i_out, exp_cos(m_acc));
      end
      n_checks++;
      if (adiff(q_out, exp_sin(m_acc)) > TOL) begin
        n_errors++; $display("FAIL pi4_q[%0d] got %0d want %0d", k, q_out, exp_sin(m_acc));
      end
      release_sample();
    end
  endtask

  task automatic test_accumulate();
    int lat;
    int want_acc[4];
    want_acc = '{1000, 2000, 3000, -2434};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      start_sample(1000, 1'b0, lat);
      n_checks++;
      if ($signed(dut.r_acc) !== want_acc[k]) begin
        n_errors++; $display("FAIL acc_step[%0d] got %0d want %0d", k, $signed(dut.r_acc), want_acc[k]);
      end
      n_checks++;
      if (adiff(i_out, exp_cos(want_acc[k])) > TOL || adiff(q_out, exp_sin(want_acc[k])) > TOL) begin
        n_errors++;
        $display("FAIL acc_iq[%0d] got %0d/%0d want %0d/%0d", k, i_out, q_out, exp_cos(want_acc[k]), exp_sin(want_acc[k]));
      end
      release_sample();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic signed [31:0] held_i;
    logic signed [31:0] held_q;
    int acc_before;
    start_sample(700, 1'b0, lat);
    held_i = i_out;
    held_q = q_out;
    acc_before = m_acc;
    @(negedge clk);
    freq_valid = 1'b1;
    freq_in    = 1234;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (iq_valid !== 1'b1 || freq_ready !== 1'b0 || i_out !== held_i || q_out !== held_q) begin
        n_errors++;
        $display("FAIL bp_hold[%0d] got valid=%b ready=%b i=%0d q=%0d want 1/0 %0d %0d",
                 c, iq_valid, freq_ready, i_out, q_out, held_i, held_q);
      end
    end
    @(negedge clk);
    freq_valid = 1'b0;
    n_checks++;
    if ($signed(dut.r_acc) !== acc_before) begin
      n_errors++; $display("FAIL bp_no_accept got acc %0d want %0d", $signed(dut.r_acc), acc_before);
    end
    release_sample();
    n_checks++;
    if (freq_ready !== 1'b1 || iq_valid !== 1'b0) begin
      n_errors++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", freq_ready, iq_valid);
    end
  endtask

  task automatic test_clear_clamp();
    int lat;
    do_reset();
    start_sample(1000, 1'b0, lat); release_sample();
    start_sample(1000, 1'b0, lat); release_sample();
    start_sample(804, 1'b1, lat);
    n_checks++;
    if ($signed(dut.r_acc) !== 804) begin n_errors++; $display("FAIL clear_accept got acc %0d want 804", $signed(dut.r_acc)); end
    release_sample();
    start_sample(5000, 1'b0, lat);
    n_checks++;
    if ($signed(dut.r_acc) !== -2414) begin n_errors++; $display("FAIL clamp_acc got %0d want -2414", $signed(dut.r_acc)); end
    n_checks++;
    if (adiff(i_out, exp_cos(-2414)) > TOL || adiff(q_out, exp_sin(-2414)) > TOL) begin
      n_errors++; $display("FAIL clamp_iq got %0d/%0d want %0d/%0d", i_out, q_out, exp_cos(-2414), exp_sin(-2414));
    end
    release_sample();
    @(negedge clk);
    phase_clear = 1'b1;
    @(posedge clk);
    #1;
    phase_clear = 1'b0;
    m_acc = 0;
    n_checks++;
    if ($signed(dut.r_acc) !== 0) begin n_errors++; $display("FAIL clear_idle got acc %0d want 0", $signed(dut.r_acc)); end
  endtask

  task automatic test_reset_mid();
    int lat;
    start_sample(900, 1'b0, lat);
    release_sample();
    @(negedge clk);
    freq_in    = 600;
    freq_valid = 1'b1;
    @(posedge clk);
    #1;
    freq_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (iq_valid !== 1'b0 || i_out !== 32'sd0 || q_out !== 32'sd0 || freq_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset got valid=%b i=%0d q=%0d ready=%b want 0 0 0 1", iq_valid, i_out, q_out, freq_ready);
    end
    n_checks++;
    if ($signed(dut.r_acc) !== 0) begin n_errors++; $display("FAIL mid_reset_acc got %0d want 0", $signed(dut.r_acc)); end
    @(negedge clk);
    reset = 1'b0;
    m_acc = 0;
    start_sample(0, 1'b0, lat);
    n_checks++;
    if (lat !== LATENCY || adiff(i_out, 1024) > TOL || adiff(q_out, 0) > TOL) begin
      n_errors++; $display("FAIL mid_reset_after got lat=%0d i=%0d q=%0d want 10 1024 0", lat, i_out, q_out);
    end
    release_sample();
  endtask

  task automatic test_random();
    int lat;
    int f;
    bit clr;
    for (int k = 0; k < 24; k++) begin
      f   = int'($urandom_range(12000)) - 6000;
      clr = ($urandom_range(7) == 0);
      start_sample(f, clr, lat);
      n_checks++;
      if (lat !== LATENCY || $signed(dut.r_acc) !== m_acc) begin
        n_errors++; $display("FAIL rand_acc[%0d] f=%0d got lat=%0d acc=%0d want 10 %0d", k, f, lat, $signed(dut.r_acc), m_acc);
      end
      n_checks++;
      if (adiff(i_out, exp_cos(m_acc)) > TOL_RAND || adiff(q_out, exp_sin(m_acc)) > TOL_RAND) begin
        n_errors++; $display("FAIL rand_iq[%0d] ph=%0d got %0d/%0d want %0d/%0d", k, m_acc, i_out, q_out, exp_cos(m_acc), exp_sin(m_acc));
      end
      release_sample();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_acc    = 0;
    test_reset();
    test_zero();
    test_quarter_steps();
    test_accumulate();
    test_backpressure();
    test_clear_clamp();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
